// File: rtl/mem_iface.sv
// -----------------------------------------------------------------------------
// mem_iface
//
// Bridges the multicycle core's level-style memory commands onto a single-port
// req/ack system bus.
//
//   * Writes are posted: the core issues a store command and moves on; the
//     transaction completes in the background.
//   * Reads start with a one-cycle init pulse. Once the bus returns the data,
//     it is lane-aligned and extended into rdata, and ready is raised.
//   * A read issued while a write is outstanding waits for that write, so
//     program order is preserved on the bus.
//   * A read issued while another read is outstanding supersedes it. The
//     in-flight transaction still runs to its ack, but its data is dropped.
//   * A write command that cannot be accepted is dropped, and the sticky err
//     flag is set.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   addr       in   byte address (sampled on init or on a write command)
//   read_op    in   load kind: LB=0 LH=1 LW=2 LBU=4 LHU=5, else LNONE
//   write_op   in   store kind: SB=0 SH=1 SW=2 SNONE=3
//   init       in   one-cycle pulse that starts a read
//   wdata      in   low-aligned store data
//   ready      out  result of the most recent init is in rdata
//   rdata      out  extended load result
//   err        out  sticky: a write command was dropped
//   bus_req    out  bus request, held until bus_ack
//   bus_we     out  1 = write transaction
//   bus_addr   out  word address (addr[AW-1:2])
//   bus_wstrb  out  byte-lane enables, 0 on reads
//   bus_wdata  out  lane-replicated store data
//   bus_rdata  in   read data, valid in the bus_ack cycle
//   bus_ack    in   one-cycle completion of the current request
// -----------------------------------------------------------------------------
module mem_iface #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic [2:0]    read_op,
    input  logic [1:0]    write_op,
    input  logic          init,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic [31:0]   rdata,
    output logic          err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-3:0] bus_addr,
    output logic [3:0]    bus_wstrb,
    output logic [31:0]   bus_wdata,
    input  logic [31:0]   bus_rdata,
    input  logic          bus_ack
);

    // Load kinds
    localparam logic [2:0] LD_B  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_W  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd4;
    localparam logic [2:0] LD_HU = 3'd5;

    // Store kinds
    localparam logic [1:0] ST_B    = 2'd0;
    localparam logic [1:0] ST_H    = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_NONE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,   // nothing outstanding
        S_WR,     // write outstanding
        S_RD,     // read outstanding, its data will be accepted
        S_WR_RD,  // write outstanding, read queued behind it
        S_RD_RD   // superseded read outstanding, new read queued
    } state_e;

    state_e          state_q;
    logic            ready_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            bus_req_q;
    logic            bus_we_q;
    logic [AW-3:0]   bus_addr_q;
    logic [3:0]      bus_wstrb_q;
    logic [31:0]     bus_wdata_q;

    // Read descriptor of the most recent init. It is the one whose data is
    // eventually accepted, so it drives both lane extraction and the address
    // of a queued read.
    logic [AW-1:0]   rd_addr_q;
    logic [2:0]      rd_op_q;

    logic            wr_cmd;
    logic [3:0]      wstrb_d;
    logic [31:0]     wdata_d;
    logic [31:0]     rdata_d;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [AW-3:0]   rd_issue_word;

    assign wr_cmd = (write_op != ST_NONE);

    // A queued read is issued with the newest descriptor. When an init
    // coincides with the issuing ack, the fresh address wins.
    assign rd_issue_word = init ? addr[AW-1:2] : rd_addr_q[AW-1:2];

    // Store lane placement: strobes select the lanes, and the data is
    // replicated so that every lane carries the right bytes.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case can leave it unassigned and infer a latch.
        wstrb_d = 4'b0000;
        wdata_d = wdata;
        case (write_op)
            ST_B: begin
                wstrb_d = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            ST_H: begin
                wstrb_d = 4'b0011 << {addr[1], 1'b0};
                wdata_d = {2{wdata[15:0]}};
            end
            ST_W: begin
                wstrb_d = 4'b1111;
            end
            default: ;
        endcase
    end

    // Load extraction from the bus word, using the captured byte offset.
    always_comb begin
        case (rd_addr_q[1:0])
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = rd_addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (rd_op_q)
            LD_B:    rdata_d = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   rdata_d = {24'h000000, ld_byte};
            LD_H:    rdata_d = {{16{ld_half[15]}}, ld_half};
            LD_HU:   rdata_d = {16'h0000, ld_half};
            LD_W:    rdata_d = bus_rdata;
            default: rdata_d = 32'h0000_0000;
        endcase
    end

    // Control FSM. All bus outputs are registered here. A transaction is
    // "issued" by loading the bus registers. On back-to-back transfers,
    // bus_req simply stays high across the ack edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values of its neighbours.
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            rd_addr_q   <= '0;
            rd_op_q     <= LD_B;
        end else begin
            // Every init records the new read and invalidates the old result.
            if (init) begin
                rd_addr_q <= addr;
                rd_op_q   <= read_op;
                ready_q   <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (wr_cmd) begin
                        // The write goes first; a simultaneous read queues.
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b1;
                        bus_addr_q  <= addr[AW-1:2];
                        bus_wstrb_q <= wstrb_d;
                        bus_wdata_q <= wdata_d;
                        state_q     <= init ? S_WR_RD : S_WR;
                    end else if (init) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= rd_issue_word;
                        bus_wstrb_q <= 4'b0000;
                        state_q     <= S_RD;
                    end
                end

                S_WR: begin
                    if (bus_ack) begin
                        if (wr_cmd) begin
                            // The ack cycle frees the bus registers, so a
                            // new write can be accepted straight away.
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= 1'b1;
                            bus_addr_q  <= addr[AW-1:2];
                            bus_wstrb_q <= wstrb_d;
                            bus_wdata_q <= wdata_d;
                            state_q     <= init ? S_WR_RD : S_WR;
                        end else if (init) begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= rd_issue_word;
                            bus_wstrb_q <= 4'b0000;
                            state_q     <= S_RD;
                        end else begin
                            bus_req_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end else begin
                        if (wr_cmd) begin
                            err_q <= 1'b1;
                        end
                        if (init) begin
                            state_q <= S_WR_RD;
                        end
                    end
                end

                S_WR_RD, S_RD_RD: begin
                    // Either the blocking write or the superseded read
                    // completes. The ack data (if any) is not ours, so just
                    // launch the queued read.
                    if (wr_cmd) begin
                        err_q <= 1'b1;
                    end
                    if (bus_ack) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= rd_issue_word;
                        bus_wstrb_q <= 4'b0000;
                        state_q     <= S_RD;
                    end
                end

                S_RD: begin
                    if (wr_cmd) begin
                        err_q <= 1'b1;
                    end
                    if (bus_ack) begin
                        if (init) begin
                            // The result has already been superseded: drop
                            // the data and issue the newer read.
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= rd_issue_word;
                            bus_wstrb_q <= 4'b0000;
                        end else begin
                            rdata_q   <= rdata_d;
                            ready_q   <= 1'b1;
                            bus_req_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end else if (init) begin
                        // The in-flight read cannot be cancelled; let it
                        // finish and discard it.
                        state_q <= S_RD_RD;
                    end
                end

                default: begin
                    bus_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_iface.sv
// -----------------------------------------------------------------------------
// tb_mem_iface
//
// Directed bench for mem_iface. The bench plays the bus slave by hand. Inputs
// change on the falling edge, and outputs are sampled on the falling edge,
// half a cycle away from the rising edge that moves the DUT.
// -----------------------------------------------------------------------------
module tb_mem_iface;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic [2:0]    read_op;
    logic [1:0]    write_op;
    logic          init;
    logic [31:0]   wdata;
    logic          ready;
    logic [31:0]   rdata;
    logic          err;
    logic          bus_req;
    logic          bus_we;
    logic [AW-3:0] bus_addr;
    logic [3:0]    bus_wstrb;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          bus_ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_iface #(.AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .read_op   (read_op),
        .write_op  (write_op),
        .init      (init),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wstrb (bus_wstrb),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Waits a bounded number of cycles for bus_req. An expired bound shows up
    // as a failed check.
    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && bus_req !== 1'b1; i++) cyc();
        check({tag, "_req"}, bus_req, 32'd1);
    endtask

    // A complete read with a single-cycle ack.
    task automatic do_read(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp,
                           input string tag);
        init = 1'b1; read_op = op; addr = a;
        cyc();
        init = 1'b0;
        wait_req(tag);
        check({tag, "_we"}, bus_we, 32'd0);
        check({tag, "_addr"}, bus_addr, a >> 2);
        check({tag, "_strb"}, bus_wstrb, 32'd0);
        bus_ack = 1'b1; bus_rdata = d;
        cyc();
        bus_ack = 1'b0;
        check({tag, "_ready"}, ready, 32'd1);
        check({tag, "_rdata"}, rdata, exp);
        check({tag, "_reqoff"}, bus_req, 32'd0);
    endtask

    // A complete posted write with a single-cycle ack.
    task automatic do_write(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wd, input string tag);
        write_op = op; addr = a; wdata = wd;
        cyc();
        write_op = 2'd3;
        check({tag, "_req"}, bus_req, 32'd1);
        check({tag, "_we"}, bus_we, 32'd1);
        check({tag, "_addr"}, bus_addr, a >> 2);
        check({tag, "_strb"}, bus_wstrb, {28'd0, exp_strb});
        check({tag, "_wdata"}, bus_wdata, exp_wd);
        bus_ack = 1'b1;
        cyc();
        bus_ack = 1'b0;
        check({tag, "_reqoff"}, bus_req, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; addr = '0; read_op = 3'd0; write_op = 2'd3; init = 1'b0;
        wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (3) cyc();

        // Reset values
        check("rst_ready", ready, 32'd0);
        check("rst_err", err, 32'd0);
        check("rst_req", bus_req, 32'd0);
        check("rst_we", bus_we, 32'd0);
        check("rst_strb", bus_wstrb, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        cyc();

        // Fetch: minimum latency. The request is visible in the cycle after
        // init, and ready in the cycle after the ack.
        do_read(3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "fetch");
        check("fetch_bus_addr", {2'b00, dut.bus_addr_q}, 32'h40);

        // Load extraction with bus word 0x80FF7F01
        do_read(3'd0, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80, "lb3");
        do_read(3'd4, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080, "lbu3");
        do_read(3'd1, 32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_80FF, "lh2");
        do_read(3'd5, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_7F01, "lhu0");
        do_read(3'd1, 32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_80FF, "lh3");
        do_read(3'd2, 32'h0000_1003, 32'h80FF_7F01, 32'h80FF_7F01, "lw3");
        do_read(3'd3, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_0000, "lnone");

        // Store lanes
        do_write(2'd0, 32'h0000_0203, 32'h1234_56AB, 4'b1000, 32'hABAB_ABAB, "sb3");
        do_write(2'd1, 32'h0000_0202, 32'h1234_56AB, 4'b1100, 32'h56AB_56AB, "sh2");
        do_write(2'd0, 32'h0000_0200, 32'h1234_56AB, 4'b0001, 32'hABAB_ABAB, "sb0");
        do_write(2'd2, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, "sw");
        check("err_clean", err, 32'd0);

        // Ordering: a read queued behind a slow write
        write_op = 2'd2; addr = 32'h0000_0300; wdata = 32'h0BAD_CAFE;
        cyc();
        write_op = 2'd3;
        init = 1'b1; read_op = 3'd2; addr = 32'h0000_0300;
        check("ord_wreq", bus_req, 32'd1);
        check("ord_wwe", bus_we, 32'd1);
        cyc();
        init = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ord_hold_we", bus_we, 32'd1);
            check("ord_hold_ready", ready, 32'd0);
            cyc();
        end
        bus_ack = 1'b1;
        cyc();
        bus_ack = 1'b0;
        check("ord_rreq", bus_req, 32'd1);
        check("ord_rwe", bus_we, 32'd0);
        check("ord_raddr", bus_addr, 32'hC0);
        check("ord_rstrb", bus_wstrb, 32'd0);
        check("ord_ready0", ready, 32'd0);
        cyc();
        check("ord_ready1", ready, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        cyc();
        bus_ack = 1'b0;
        check("ord_ready", ready, 32'd1);
        check("ord_rdata", rdata, 32'h1122_3344);

        // Overlap: a second init while a read is in flight
        init = 1'b1; read_op = 3'd2; addr = 32'h0000_0400;
        cyc();
        init = 1'b1; addr = 32'h0000_0404;
        check("ovl_req1", bus_addr, 32'h100);
        cyc();
        init = 1'b0;
        check("ovl_stale_addr", bus_addr, 32'h100);
        bus_ack = 1'b1; bus_rdata = 32'hAAAA_AAAA;
        cyc();
        bus_ack = 1'b0;
        check("ovl_req2", bus_req, 32'd1);
        check("ovl_addr2", bus_addr, 32'h101);
        check("ovl_ready0", ready, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        cyc();
        bus_ack = 1'b0;
        check("ovl_ready", ready, 32'd1);
        check("ovl_rdata", rdata, 32'h5555_5555);

        // Drop: a write while another write is outstanding
        write_op = 2'd2; addr = 32'h0000_0500; wdata = 32'h0101_0101;
        cyc();
        write_op = 2'd0; addr = 32'h0000_0600; wdata = 32'h0000_00EE;
        cyc();
        write_op = 2'd3;
        check("drop_err", err, 32'd1);
        check("drop_addr", bus_addr, 32'h140);
        check("drop_strb", bus_wstrb, 32'hF);
        check("drop_wdata", bus_wdata, 32'h0101_0101);
        bus_ack = 1'b1;
        cyc();
        bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drop_noreq", bus_req, 32'd0);
            cyc();
        end
        check("drop_sticky", err, 32'd1);

        // A write in the ack cycle of a write is accepted
        write_op = 2'd2; addr = 32'h0000_0700; wdata = 32'h7777_7777;
        cyc();
        bus_ack = 1'b1; write_op = 2'd0; addr = 32'h0000_0701; wdata = 32'h0000_005A;
        cyc();
        bus_ack = 1'b0; write_op = 2'd3;
        check("b2b_req", bus_req, 32'd1);
        check("b2b_we", bus_we, 32'd1);
        check("b2b_addr", bus_addr, 32'h1C0);
        check("b2b_strb", bus_wstrb, 32'h2);
        check("b2b_wdata", bus_wdata, 32'h5A5A_5A5A);
        bus_ack = 1'b1;
        cyc();
        bus_ack = 1'b0;
        check("b2b_done", bus_req, 32'd0);

        // Reset with a read pending
        init = 1'b1; read_op = 3'd2; addr = 32'h0000_0800;
        cyc();
        init = 1'b0;
        check("rstmid_req", bus_req, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rstmid_reqoff", bus_req, 32'd0);
        check("rstmid_ready", ready, 32'd0);
        check("rstmid_err", err, 32'd0);
        do_read(3'd2, 32'h0000_0104, 32'h0BAD_F00D, 32'h0BAD_F00D, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_iface.md
# mem_iface

Memory interface between the multicycle core's control/datapath and the single-port system bus. It accepts the core's level-style memory commands (`init`, `read_op`, `write_op`, `addr`) and runs them as req/ack bus transactions. Writes are posted and complete in the background; reads raise `ready` once lane-aligned, extended data is held in `rdata`. A read issued behind a pending write waits for that write, so program order is preserved.

## Interface
- `AW`, 32, byte-address width; `bus_addr` is the word address, `AW-2` bits.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `addr`  in  AW  byte address of the access, sampled on `init` or on a write.
- `read_op`  in  3  load kind, sampled on `init`: LB=0, LH=1, LW=2, LBU=4, LHU=5; any other value is LNONE.
- `write_op`  in  2  store kind: SB=0, SH=1, SW=2, SNONE=3. Any non-SNONE cycle is one write command.
- `init`  in  1  one-cycle pulse that starts a read.
- `wdata`  in  32  store data, low-aligned, sampled with `write_op`.
- `ready`  out  1  the result of the most recent `init` is in `rdata`.
- `rdata`  out  32  extended load result.
- `err`  out  1  sticky flag: a write command was dropped.
- `bus_req`  out  1  bus request, held until `bus_ack`.
- `bus_we`  out  1  1 = write transaction.
- `bus_addr`  out  AW-2  word address, `addr[AW-1:2]`.
- `bus_wstrb`  out  4  byte-lane enables; 0 on reads.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_rdata`  in  32  read data, valid in the `bus_ack` cycle.
- `bus_ack`  in  1  one-cycle completion for the current request.

## Operation
- States:
  - IDLE
  - WR: write outstanding
  - RD: read outstanding
  - WR_RD: write outstanding, read queued
  - RD_RD: stale read outstanding, new read queued
- IDLE transitions:
  - write command → WR.
  - `init` → RD.
  - Write and `init` in the same cycle → WR_RD; the write is issued first.
- WR transitions:
  - `init` → WR_RD.
  - `bus_ack` → IDLE. If `init` coincides with `bus_ack`, go to RD.
- WR_RD, on `bus_ack`: → RD, issuing the queued read.
- RD transitions:
  - `bus_ack` → IDLE. Capture data and set `ready`.
  - `init` before the ack → RD_RD. The in-flight transaction cannot be cancelled.
  - `init` coinciding with `bus_ack` → RD. Discard the ack data and issue the new read.
- RD_RD, on `bus_ack`: discard the data, → RD with the queued read.
- A write command in any state other than IDLE is dropped, and `err` is set to 1. Exception: a write in the cycle WR receives `bus_ack` is accepted, WR → WR.
- Read capture on `init`: `addr`, `read_op`. Write capture: `addr`, `write_op`, `wdata`.
- Read extraction, using the captured `addr[1:0]`:
  - LB/LBU: byte lane `addr[1:0]`, sign- or zero-extended to 32 bits.
  - LH/LHU: halfword lane `addr[1]`; `addr[0]` is ignored.
  - LW: all 32 bits; `addr[1:0]` are ignored.
  - LNONE: `rdata` = 0, with `ready` still set.
- Write lanes:
  - SB: strobe `1 << addr[1:0]`, `wdata[7:0]` replicated to all 4 lanes.
  - SH: strobe `4'b0011 << 2*addr[1]`, `wdata[15:0]` replicated to both halves.
  - SW: strobe `4'b1111`.
- `ready` clears on the clock edge after `init`. It sets on the edge after the accepting `bus_ack`. Once set, it and `rdata` hold until the next `init`.

## Timing
- Reset values:
  - state IDLE
  - `ready`, `err`, `bus_req`, `bus_we` = 0
  - `bus_wstrb` = 0, `rdata` = 0
- All bus outputs are registered. `bus_req` rises the cycle after the command is captured and falls the cycle after `bus_ack`.
- Back-to-back: when the next transaction is already queued, `bus_req` stays high across the ack cycle and the address, `bus_we` and strobes update on the same edge.
- Read latency:
  - `init` at t, ack at t+1 gives `ready` = 1 at t+2. This is the minimum.
  - In general, `ready` = 1 one cycle after the accepting ack.
- Write: a write command at t puts `bus_req` at t+1. The core never waits on it.
- Read behind a write: `init` at t while WR, write ack at u ≥ t. The read `bus_req` is asserted at u+1 and `ready` stays 0 until that read's ack.
- Reset mid-transaction: all state and queues are cleared. The bus slave must tolerate `bus_req` dropping without an ack.

## Test plan
- Fetch: `init`, LW, addr=0x100, ack one cycle later with `bus_rdata`=0xDEADBEEF → `bus_addr`=0x40, `ready`=1 two cycles after `init`, `rdata`=0xDEADBEEF.
- Loads: `bus_rdata`=0x80FF7F01.
  - LB at +3 → 0xFFFFFF80; LBU at +3 → 0x00000080.
  - LH at +2 → 0xFFFF80FF; LHU at +0 → 0x00007F01.
- Stores:
  - SB addr=0x203, `wdata`=0x1234_56AB → `bus_wstrb`=1000, `bus_wdata`=0xABABABAB.
  - SH addr=0x202 → `bus_wstrb`=1100.
- Ordering: SW to 0x300 with ack delayed 5 cycles, then `init` LW 0x300 the next cycle → write ack precedes the read `bus_req`, and `ready` stays 0 until the read ack.
- Overlap/drop: a second `init` while a read is outstanding → the first data is discarded and `rdata` holds the second read's data. A write while WR (not in the ack cycle) → `err`=1, only one write appears on the bus.
- Reset asserted with a read pending → next cycle `bus_req`=0, `ready`=0, `err`=0, and a subsequent `init` works normally.
